// File: rtl/c432_harness_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : c432_harness_pkg
//  Purpose  : Shared constants and types for the c432 trojan-detection
//             harness (c432 I/O widths, analyzer FSM states, MISR defaults).
//  Revision : 1.0  initial release
// ============================================================================
package c432_harness_pkg;

    // c432 primary output and input counts
    localparam int C432_OUT_W = 7;
    localparam int C432_IN_W  = 36;

    // Default MISR feedback polynomial and load value
    localparam logic [15:0] C432_MISR_POLY = 16'h1021;
    localparam logic [15:0] C432_MISR_SEED = 16'h0000;

    // Response-analyzer run states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

endpackage : c432_harness_pkg
`default_nettype wire

// File: rtl/misr.sv
`default_nettype none
// ============================================================================
//  Module   : misr
//  Purpose  : Multiple-input signature register. Shifts left, folds the
//             shifted-out MSB back through POLY and XORs in the zero-extended
//             input word on every enabled cycle.
//  Revision : 1.0  initial release
// ============================================================================
module misr #(
    parameter int               SIG_W = 16,
    parameter int               DIN_W = 7,
    parameter logic [SIG_W-1:0] POLY  = 16'h1021
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [SIG_W-1:0] seed,
    input  logic             en,
    input  logic [DIN_W-1:0] din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;
    logic [SIG_W-1:0] w_din_ext;

    assign w_din_ext = SIG_W'(din);

    // Next signature: load has priority over a compaction step
    always_comb begin
        sig_d = sig_q;
        if (load) begin
            sig_d = seed;
        end else if (en) begin
            sig_d = {sig_q[SIG_W-2:0], 1'b0}
                  ^ (sig_q[SIG_W-1] ? POLY : '0)
                  ^ w_din_ext;
        end
    end

    // Signature register; reset returns to the seed value
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= seed;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule : misr
`default_nettype wire

// File: rtl/c432_response_analyzer.sv
`default_nettype none
// ============================================================================
//  Module   : c432_response_analyzer
//  Purpose  : Compares golden and suspect c432 response streams: compacts each
//             into a MISR signature, counts mismatching pairs, records the
//             first mismatch index and raises a trojan flag at run end.
//  Revision : 1.0  initial release
// ============================================================================
module c432_response_analyzer
    import c432_harness_pkg::*;
#(
    parameter int               OUT_W = C432_OUT_W,
    parameter int               SIG_W = 16,
    parameter int               CNT_W = 16,
    parameter logic [SIG_W-1:0] POLY  = C432_MISR_POLY,
    parameter logic [SIG_W-1:0] SEED  = C432_MISR_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_patterns,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OUT_W-1:0] golden_out,
    input  logic [OUT_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] mismatch_count,
    output logic             first_mismatch_valid,
    output logic [CNT_W-1:0] first_mismatch_idx,
    output logic [SIG_W-1:0] golden_sig,
    output logic [SIG_W-1:0] dut_sig,
    output logic             trojan_flag
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] mcnt_q, mcnt_d;
    logic [CNT_W-1:0] fidx_q, fidx_d;
    logic             fvalid_q, fvalid_d;
    logic             flag_q, flag_d;

    logic             w_load;
    logic             w_accept;
    logic             w_mismatch;
    logic             w_flag_now;

    assign w_mismatch = (golden_out != dut_out);
    // Results are final while in FIN, so the verdict can be formed from them
    assign w_flag_now = (mcnt_q != '0) || (golden_sig != dut_sig);

    // Next-state and result bookkeeping for the run sequencer
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        mcnt_d   = mcnt_q;
        fidx_d   = fidx_q;
        fvalid_d = fvalid_q;
        flag_d   = flag_q;
        w_load   = 1'b0;
        w_accept = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    w_load   = 1'b1;
                    target_d = num_patterns;
                    cnt_d    = '0;
                    mcnt_d   = '0;
                    fidx_d   = '0;
                    fvalid_d = 1'b0;
                    flag_d   = 1'b0;
                    state_d  = (num_patterns == '0) ? FIN : RUN;
                end
            end
            RUN: begin
                if (in_valid) begin
                    w_accept = 1'b1;
                    if (w_mismatch) begin
                        // Saturate rather than wrap so a huge count never reads as clean
                        if (mcnt_q != '1) begin
                            mcnt_d = mcnt_q + CNT_W'(1);
                        end
                        if (!fvalid_q) begin
                            fidx_d   = cnt_q;
                            fvalid_d = 1'b1;
                        end
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == target_q - CNT_W'(1)) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                flag_d  = w_flag_now;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            target_q <= '0;
            cnt_q    <= '0;
            mcnt_q   <= '0;
            fidx_q   <= '0;
            fvalid_q <= 1'b0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            mcnt_q   <= mcnt_d;
            fidx_q   <= fidx_d;
            fvalid_q <= fvalid_d;
            flag_q   <= flag_d;
        end
    end

    misr #(
        .SIG_W (SIG_W),
        .DIN_W (OUT_W),
        .POLY  (POLY)
    ) u_misr_golden (
        .clk  (clk),
        .rst  (rst),
        .load (w_load),
        .seed (SEED),
        .en   (w_accept),
        .din  (golden_out),
        .sig  (golden_sig)
    );

    misr #(
        .SIG_W (SIG_W),
        .DIN_W (OUT_W),
        .POLY  (POLY)
    ) u_misr_dut (
        .clk  (clk),
        .rst  (rst),
        .load (w_load),
        .seed (SEED),
        .en   (w_accept),
        .din  (dut_out),
        .sig  (dut_sig)
    );

    assign busy                 = (state_q == RUN);
    assign in_ready             = (state_q == RUN);
    assign done                 = (state_q == FIN);
    assign mismatch_count       = mcnt_q;
    assign first_mismatch_valid = fvalid_q;
    assign first_mismatch_idx   = fidx_q;
    // Verdict is visible during the done cycle and held afterwards
    assign trojan_flag          = (state_q == FIN) ? w_flag_now : flag_q;

endmodule : c432_response_analyzer
`default_nettype wire

// File: tb/tb_c432_response_analyzer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_c432_response_analyzer
//  Purpose  : Directed self-checking bench for c432_response_analyzer.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_c432_response_analyzer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] num_patterns;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  golden_out;
    logic [6:0]  dut_out;
    logic        busy;
    logic        done;
    logic [15:0] mismatch_count;
    logic        first_mismatch_valid;
    logic [15:0] first_mismatch_idx;
    logic [15:0] golden_sig;
    logic [15:0] dut_sig;
    logic        trojan_flag;

    int checks = 0;
    int errors = 0;

    c432_response_analyzer dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .num_patterns         (num_patterns),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .golden_out           (golden_out),
        .dut_out              (dut_out),
        .busy                 (busy),
        .done                 (done),
        .mismatch_count       (mismatch_count),
        .first_mismatch_valid (first_mismatch_valid),
        .first_mismatch_idx   (first_mismatch_idx),
        .golden_sig           (golden_sig),
        .dut_sig              (dut_sig),
        .trojan_flag          (trojan_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a one-cycle start pulse; returns with the DUT already past the start edge
    task automatic pulse_start(input logic [15:0] n);
        start        = 1'b1;
        num_patterns = n;
        tick();
        start        = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b expected 0", in_ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
        checks++; if (mismatch_count !== 16'd0) begin errors++; $display("FAIL reset_mcount: got %0d expected 0", mismatch_count); end
        checks++; if (first_mismatch_valid !== 1'b0 || first_mismatch_idx !== 16'd0) begin errors++; $display("FAIL reset_first: got %0b/%0d expected 0/0", first_mismatch_valid, first_mismatch_idx); end
        checks++; if (golden_sig !== 16'h0000 || dut_sig !== 16'h0000) begin errors++; $display("FAIL reset_sigs: got %h/%h expected 0000/0000", golden_sig, dut_sig); end
        checks++; if (trojan_flag !== 1'b0) begin errors++; $display("FAIL reset_flag: got %0b expected 0", trojan_flag); end
    endtask

    // Identical streams 01,00,7F,55 -> signature 00A3 on both, no flag
    task automatic test_identical();
        logic [6:0] pats [4];
        pats[0] = 7'h01; pats[1] = 7'h00; pats[2] = 7'h7F; pats[3] = 7'h55;
        pulse_start(16'd4);
        checks++; if (busy !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL ident_run: got busy=%0b ready=%0b expected 1/1", busy, in_ready); end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; golden_out = pats[i]; dut_out = pats[i];
            tick();
            if (i < 3) begin
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL ident_early_done: got %0b expected 0 at accept %0d", done, i); end
            end
        end
        in_valid = 1'b0;
        checks++; if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL ident_done: got done=%0b busy=%0b ready=%0b expected 1/0/0", done, busy, in_ready); end
        checks++; if (mismatch_count !== 16'd0 || first_mismatch_valid !== 1'b0) begin errors++; $display("FAIL ident_counts: got %0d/%0b expected 0/0", mismatch_count, first_mismatch_valid); end
        checks++; if (golden_sig !== 16'h00A3 || dut_sig !== 16'h00A3) begin errors++; $display("FAIL ident_sigs: got %h/%h expected 00a3/00a3", golden_sig, dut_sig); end
        checks++; if (trojan_flag !== 1'b0) begin errors++; $display("FAIL ident_flag: got %0b expected 0", trojan_flag); end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ident_after: got done=%0b busy=%0b expected 0/0", done, busy); end
    endtask

    // Two-step MISR check from seed 0: 01 -> 0001, 00 -> 0002
    task automatic test_misr();
        pulse_start(16'd2);
        in_valid = 1'b1; golden_out = 7'h01; dut_out = 7'h01;
        tick();
        checks++; if (golden_sig !== 16'h0001 || dut_sig !== 16'h0001) begin errors++; $display("FAIL misr_step1: got %h/%h expected 0001/0001", golden_sig, dut_sig); end
        golden_out = 7'h00; dut_out = 7'h00;
        tick();
        in_valid = 1'b0;
        checks++; if (golden_sig !== 16'h0002 || dut_sig !== 16'h0002 || done !== 1'b1) begin errors++; $display("FAIL misr_step2: got %h/%h done=%0b expected 0002/0002 done=1", golden_sig, dut_sig, done); end
        tick();
    endtask

    // Single mismatch at index 2: golden sig 0040, dut sig 0044
    task automatic test_mismatch();
        pulse_start(16'd5);
        for (int i = 0; i < 5; i++) begin
            in_valid   = 1'b1;
            golden_out = (i == 2) ? 7'h10 : 7'h00;
            dut_out    = (i == 2) ? 7'h11 : 7'h00;
            tick();
        end
        in_valid = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL mis_done: got %0b expected 1", done); end
        checks++; if (mismatch_count !== 16'd1) begin errors++; $display("FAIL mis_count: got %0d expected 1", mismatch_count); end
        checks++; if (first_mismatch_valid !== 1'b1 || first_mismatch_idx !== 16'd2) begin errors++; $display("FAIL mis_first: got %0b/%0d expected 1/2", first_mismatch_valid, first_mismatch_idx); end
        checks++; if (golden_sig !== 16'h0040 || dut_sig !== 16'h0044) begin errors++; $display("FAIL mis_sigs: got %h/%h expected 0040/0044", golden_sig, dut_sig); end
        checks++; if (trojan_flag !== 1'b1) begin errors++; $display("FAIL mis_flag_done: got %0b expected 1", trojan_flag); end
        tick();
        tick();
        checks++; if (trojan_flag !== 1'b1 || mismatch_count !== 16'd1) begin errors++; $display("FAIL mis_hold: got flag=%0b count=%0d expected 1/1", trojan_flag, mismatch_count); end
    endtask

    // Empty run, then in_valid while idle must not be accepted
    task automatic test_zero();
        pulse_start(16'd0);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL zero_done: got done=%0b busy=%0b expected 1/0", done, busy); end
        checks++; if (mismatch_count !== 16'd0 || first_mismatch_valid !== 1'b0) begin errors++; $display("FAIL zero_counts: got %0d/%0b expected 0/0", mismatch_count, first_mismatch_valid); end
        checks++; if (golden_sig !== 16'h0000 || dut_sig !== 16'h0000) begin errors++; $display("FAIL zero_sigs: got %h/%h expected 0000/0000", golden_sig, dut_sig); end
        checks++; if (trojan_flag !== 1'b0) begin errors++; $display("FAIL zero_flag: got %0b expected 0", trojan_flag); end
        tick();
        in_valid = 1'b1; golden_out = 7'h7F; dut_out = 7'h00;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_ready: got %0b expected 0", in_ready); end
        tick();
        tick();
        in_valid = 1'b0;
        checks++; if (mismatch_count !== 16'd0 || golden_sig !== 16'h0000 || done !== 1'b0) begin errors++; $display("FAIL idle_accept: got count=%0d sig=%h done=%0b expected 0/0000/0", mismatch_count, golden_sig, done); end
    endtask

    // Stalls: valid,idle,idle,valid,idle,valid with a start pulse mid-run
    task automatic test_gaps();
        logic [5:0] vmask;
        logic [6:0] pat;
        vmask = 6'b101001;
        pat   = 7'h01;
        pulse_start(16'd3);
        for (int i = 0; i < 6; i++) begin
            if (vmask[i]) begin
                in_valid = 1'b1; golden_out = pat; dut_out = pat;
                pat = pat + 7'h01;
            end else begin
                in_valid = 1'b0; golden_out = 7'h7F; dut_out = 7'h00;
            end
            start = (i == 2);
            num_patterns = 16'd9;
            tick();
            start = 1'b0;
            if (i == 4) begin
                checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL gap_stall: got done=%0b busy=%0b expected 0/1", done, busy); end
            end
        end
        in_valid = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL gap_done: got %0b expected 1", done); end
        checks++; if (mismatch_count !== 16'd0 || golden_sig !== 16'h0003 || dut_sig !== 16'h0003) begin errors++; $display("FAIL gap_result: got count=%0d sigs=%h/%h expected 0/0003/0003", mismatch_count, golden_sig, dut_sig); end
        tick();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL gap_no_restart: got busy=%0b done=%0b expected 0/0", busy, done); end
    endtask

    // Reset after 2 of 6 accepts (with start held alongside rst), then a clean run
    task automatic test_rst_mid();
        pulse_start(16'd6);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; golden_out = 7'h01; dut_out = 7'h02;
            tick();
        end
        checks++; if (mismatch_count !== 16'd2) begin errors++; $display("FAIL rst_pre: got %0d expected 2", mismatch_count); end
        rst = 1'b1; start = 1'b1; num_patterns = 16'd3;
        tick();
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_state: got busy=%0b ready=%0b done=%0b expected 0/0/0", busy, in_ready, done); end
        checks++; if (mismatch_count !== 16'd0 || first_mismatch_valid !== 1'b0 || first_mismatch_idx !== 16'd0) begin errors++; $display("FAIL rst_results: got %0d/%0b/%0d expected 0/0/0", mismatch_count, first_mismatch_valid, first_mismatch_idx); end
        checks++; if (golden_sig !== 16'h0000 || dut_sig !== 16'h0000 || trojan_flag !== 1'b0) begin errors++; $display("FAIL rst_sigs: got %h/%h flag=%0b expected 0000/0000/0", golden_sig, dut_sig, trojan_flag); end
        pulse_start(16'd1);
        in_valid = 1'b1; golden_out = 7'h05; dut_out = 7'h05;
        tick();
        in_valid = 1'b0;
        checks++; if (done !== 1'b1 || golden_sig !== 16'h0005 || dut_sig !== 16'h0005 || mismatch_count !== 16'd0 || trojan_flag !== 1'b0) begin errors++; $display("FAIL rst_fresh: got done=%0b sigs=%h/%h count=%0d flag=%0b expected 1/0005/0005/0/0", done, golden_sig, dut_sig, mismatch_count, trojan_flag); end
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_patterns = 16'd0;
        in_valid = 1'b0; golden_out = 7'h00; dut_out = 7'h00;
        test_reset();
        test_identical();
        test_misr();
        test_mismatch();
        test_zero();
        test_gaps();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_c432_response_analyzer
`default_nettype wire

// File: doc/c432_response_analyzer.md
Name: c432_response_analyzer

Overview:
- Downstream stage of the c432 circuit-under-test in the trojan-detection harness.
- Consumes the 7-bit primary outputs (N223, N329, N370, N421, N430, N431, N432) of a golden c432 and a suspect c432, both driven by the same pattern stream.
- Compacts each output stream into a MISR signature, counts per-pattern mismatches and records the index of the first mismatch.
- Raises a trojan flag at the end of each run. The evolutionary pattern search uses these results as its fitness input.

Parameters:
- OUT_W, 7, width of each response vector (c432 output count)
- SIG_W, 16, MISR signature width; must be >= OUT_W
- CNT_W, 16, width of the pattern counter, mismatch counter and index fields
- POLY, 16'h1021, MISR feedback polynomial (taps on bit SIG_W-1 shift-out)
- SEED, 16'h0000, MISR value loaded on start

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins a run; honoured only in IDLE
- num_patterns  input  CNT_W  number of response pairs in this run; sampled on start
- in_valid  input  1  golden_out/dut_out hold a valid response pair
- in_ready  output  1  analyzer accepts a pair this cycle
- golden_out  input  OUT_W  golden c432 response
- dut_out  input  OUT_W  suspect c432 response
- busy  output  1  run in progress
- done  output  1  one-cycle pulse at run completion
- mismatch_count  output  CNT_W  number of pairs with golden_out != dut_out; saturating
- first_mismatch_valid  output  1  at least one mismatch seen this run
- first_mismatch_idx  output  CNT_W  0-based index of the first mismatching pair
- golden_sig  output  SIG_W  MISR signature of the golden stream
- dut_sig  output  SIG_W  MISR signature of the suspect stream
- trojan_flag  output  1  set at done if mismatch_count != 0 or golden_sig != dut_sig

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - State: IDLE.
  - in_ready, busy, done, first_mismatch_valid, trojan_flag = 0.
  - mismatch_count, first_mismatch_idx and the pattern counter = 0.
  - golden_sig and dut_sig = SEED.
- FSM has three states: IDLE, RUN, FIN.
- IDLE:
  - On start, load both MISRs with SEED and clear the counters, first_mismatch_valid and trojan_flag.
  - Latch num_patterns into target.
  - If target is 0, go to FIN; otherwise go to RUN.
  - The previous run's results stay visible until the next start.
- RUN:
  - busy=1 and in_ready=1.
  - An accept occurs when in_valid && in_ready. Cycles without in_valid are stalls and change nothing.
  - On each accept:
    - Each MISR updates as sig <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ zero-extended response.
    - If golden_out != dut_out, mismatch_count increments, saturating at all-ones.
    - On the first mismatch, first_mismatch_idx <= pattern counter and first_mismatch_valid <= 1.
    - The pattern counter increments.
  - When the accept is pair number target (counter == target-1), go to FIN.
- FIN:
  - Lasts one cycle: busy=0, in_ready=0, done=1.
  - trojan_flag is registered this cycle from the final count and signatures.
  - Return to IDLE.
- Latency: results are registered and updated the cycle after each accept. done asserts the cycle after the final accept, with all result outputs already final in that cycle.
- Boundary conditions:
  - start while busy or in FIN: ignored.
  - in_valid in IDLE or FIN: not accepted (in_ready=0).
  - start coinciding with rst: rst wins.
  - rst mid-RUN: immediate return to reset values; partial results are discarded.
  - Counter wrap cannot occur, since target <= 2^CNT_W-1.
  - mismatch_count saturates and never wraps.

Decomposition:
- Shared package c432_harness_pkg holds:
  - the localparams C432_OUT_W=7 and C432_IN_W=36,
  - the FSM state enum (IDLE/RUN/FIN),
  - the default MISR polynomial and seed.
- One sub-module, misr (params SIG_W, DIN_W, POLY), with ports clk, rst, load, seed, en, din, sig. It is instantiated twice, once per response stream.

Test Plan:
- Identical streams, num_patterns=4 (7'h01, 7'h00, 7'h7F, 7'h55) -> done 5 cycles after start; mismatch_count=0; first_mismatch_valid=0; golden_sig==dut_sig; trojan_flag=0.
- MISR check, SEED=0: 7'h01 then 7'h00 -> sig 16'h0001 after the first accept and 16'h0002 after the second, matching the bench reference model.
- num_patterns=5 with dut differing only at index 2 (golden 7'h10, dut 7'h11) -> mismatch_count=1; first_mismatch_idx=2; signatures differ; trojan_flag=1.
- num_patterns=0 -> done on the cycle after start; counts 0; both signatures = SEED; trojan_flag=0.
- num_patterns=3 with in_valid gaps (valid, idle, idle, valid, idle, valid) -> exactly 3 accepts; done the cycle after the last valid; a start pulse mid-run is ignored.
- rst asserted after 2 of 6 accepts -> next cycle: all outputs at reset values and state IDLE; a fresh start runs cleanly.
